// File: rtl/window_anchor_scheduler.sv
// window_anchor_scheduler
// Raster-scans every legal window anchor of an image and hands one anchor
// address per valid/ready transfer to the window address path. Supports
// pause (hold without dropping the presented anchor), abort (silent return
// to idle) and a one-cycle done pulse after the final transfer.
module window_anchor_scheduler #(
    parameter int H_IMAGE_LEN  = 35,
    parameter int V_IMAGE_LEN  = 35,
    parameter int H_WINDOW_LEN = 5,
    parameter int V_WINDOW_LEN = 5,
    parameter int H_STRIDE     = 1,
    parameter int V_STRIDE     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        pause,
    input  logic [31:0] base_addr_in,
    input  logic        anchor_ready,
    output logic        anchor_valid,
    output logic [31:0] anchor_addr,
    output logic        anchor_last,
    output logic [15:0] col_idx,
    output logic [15:0] row_idx,
    output logic [31:0] anchor_cnt,
    output logic        busy,
    output logic        done
);

    // Number of anchor positions per row / column of the frame
    localparam int NH = (H_IMAGE_LEN - H_WINDOW_LEN) / H_STRIDE + 1;
    localparam int NV = (V_IMAGE_LEN - V_WINDOW_LEN) / V_STRIDE + 1;

    localparam logic [15:0] COL_MAX = 16'(NH - 1);
    localparam logic [15:0] ROW_MAX = 16'(NV - 1);
    localparam logic [31:0] H_STEP  = 32'(H_STRIDE);
    localparam logic [31:0] V_STEP  = 32'(V_STRIDE * H_IMAGE_LEN);
    // A frame with a single anchor position flags its first anchor as last
    localparam logic SINGLE = (NH == 1) && (NV == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] row_base_q, row_base_d;
    logic        last_q, last_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic [31:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        xfer;

    assign xfer = valid_q & anchor_ready;

    // Next-state logic: FSM transitions and anchor advance on each transfer
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        last_d     = last_q;
        col_d      = col_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // start takes precedence over abort here; abort is a no-op in idle
                if (start) begin
                    state_d    = S_RUN;
                    valid_d    = 1'b1;
                    addr_d     = base_addr_in;
                    row_base_d = base_addr_in;
                    col_d      = '0;
                    row_d      = '0;
                    cnt_d      = '0;
                    last_d     = SINGLE;
                    busy_d     = 1'b1;
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (xfer) begin
                    cnt_d = cnt_q + 32'd1;
                    if (last_q) begin
                        // Final anchor accepted: finish regardless of pause
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (col_q == COL_MAX) begin
                            col_d      = '0;
                            row_d      = row_q + 16'd1;
                            row_base_d = row_base_q + V_STEP;
                            addr_d     = row_base_q + V_STEP;
                        end else begin
                            col_d  = col_q + 16'd1;
                            addr_d = addr_q + H_STEP;
                        end
                        last_d = (col_d == COL_MAX) && (row_d == ROW_MAX);
                        if (pause) begin
                            state_d = S_PAUSED;
                            valid_d = 1'b0;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end
                end else if (pause) begin
                    // Presented anchor is kept and re-offered after the pause
                    state_d = S_PAUSED;
                    valid_d = 1'b0;
                end
            end

            S_PAUSED: begin
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (!pause) begin
                    state_d = S_RUN;
                    valid_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            row_base_q <= '0;
            last_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            last_q     <= last_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign anchor_valid = valid_q;
    assign anchor_addr  = addr_q;
    assign anchor_last  = last_q;
    assign col_idx      = col_q;
    assign row_idx      = row_q;
    assign anchor_cnt   = cnt_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_window_anchor_scheduler.sv
// Scoreboard bench for window_anchor_scheduler: the full expected anchor
// sequence of a frame is queued when the frame is started and popped on
// every observed transfer.
module tb_window_anchor_scheduler;

    localparam int H_IMG = 35;
    localparam int V_IMG = 35;
    localparam int NH    = 31;
    localparam int NV    = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pause = 1'b0;
    logic [31:0] base_addr_in = '0;
    logic        anchor_ready = 1'b0;
    logic        anchor_valid;
    logic [31:0] anchor_addr;
    logic        anchor_last;
    logic [15:0] col_idx;
    logic [15:0] row_idx;
    logic [31:0] anchor_cnt;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] col;
        logic [15:0] row;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_seen = 0;

    window_anchor_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .base_addr_in (base_addr_in),
        .anchor_ready (anchor_ready),
        .anchor_valid (anchor_valid),
        .anchor_addr  (anchor_addr),
        .anchor_last  (anchor_last),
        .col_idx      (col_idx),
        .row_idx      (row_idx),
        .anchor_cnt   (anchor_cnt),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Queue the whole raster sequence of a frame starting at base
    task automatic push_frame(input logic [31:0] base);
        exp_t e;
        for (int r = 0; r < NV; r++) begin
            for (int c = 0; c < NH; c++) begin
                e.addr = base + 32'(r * H_IMG) + 32'(c);
                e.col  = 16'(c);
                e.row  = 16'(r);
                e.last = (r == NV - 1) && (c == NH - 1);
                sb.push_back(e);
            end
        end
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (done) done_seen++;
        if (anchor_valid && anchor_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("xfer_addr", 64'(anchor_addr), 64'(e.addr));
                check("xfer_col",  64'(col_idx),     64'(e.col));
                check("xfer_row",  64'(row_idx),     64'(e.row));
                check("xfer_last", 64'(anchor_last), 64'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [31:0] base);
        base_addr_in = base;
        push_frame(base);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_valid", 64'(anchor_valid), 64'd1);
        check("first_addr",  64'(anchor_addr),  64'(base));
        check("first_col",   64'(col_idx),      64'd0);
        check("first_row",   64'(row_idx),      64'd0);
        check("first_cnt",   64'(anchor_cnt),   64'd0);
        check("first_busy",  64'(busy),         64'd1);
    endtask

    task automatic finish_frame(input int budget, input bit rand_ready);
        int n = 0;
        done_seen = 0;
        while (done_seen == 0 && n < budget) begin
            if (rand_ready) anchor_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("done_seen", 64'(done_seen), 64'd1);
        tick();
        tick();
        check("done_one_cycle", 64'(done_seen), 64'd1);
        check("end_cnt",   64'(anchor_cnt),   64'd961);
        check("end_valid", 64'(anchor_valid), 64'd0);
        check("end_busy",  64'(busy),         64'd0);
        check("sb_drained", 64'(sb.size()),   64'd0);
    endtask

    initial begin
        int  n;
        bit  row1_seen;
        bit  start_poked;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(anchor_valid), 64'd0);
        check("rst_addr",  64'(anchor_addr),  64'd0);
        check("rst_cnt",   64'(anchor_cnt),   64'd0);
        check("rst_busy",  64'(busy),         64'd0);
        check("rst_done",  64'(done),         64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full frame with ready held high
        anchor_ready = 1'b1;
        begin_frame(32'd0);
        finish_frame(2000, 1'b0);

        // Backpressure, pause and abort in one frame
        anchor_ready = 1'b1;
        begin_frame(32'd0);
        n = 0;
        while (anchor_addr != 32'd3 && n < 50) begin tick(); n++; end
        anchor_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 64'(anchor_valid), 64'd1);
            check("stall_addr",  64'(anchor_addr),  64'd3);
            check("stall_col",   64'(col_idx),      64'd3);
        end
        anchor_ready = 1'b1;
        tick();
        check("after_stall_addr", 64'(anchor_addr), 64'd4);
        n = 0;
        while (col_idx != 16'd10 && n < 50) begin tick(); n++; end
        anchor_ready = 1'b0;
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pause_valid", 64'(anchor_valid), 64'd0);
            check("pause_addr",  64'(anchor_addr),  64'd10);
            check("pause_busy",  64'(busy),         64'd1);
        end
        pause = 1'b0;
        tick();
        check("resume_valid", 64'(anchor_valid), 64'd1);
        check("resume_addr",  64'(anchor_addr),  64'd10);
        anchor_ready = 1'b1;
        n = 0;
        while (!(row_idx == 16'd2 && col_idx == 16'd7) && n < 200) begin tick(); n++; end
        check("abort_pos_addr", 64'(anchor_addr), 64'(2 * H_IMG + 7));
        done_seen = 0;
        anchor_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 64'(anchor_valid), 64'd0);
        check("abort_busy",  64'(busy),         64'd0);
        sb.delete();
        for (int i = 0; i < 5; i++) tick();
        check("abort_no_done", 64'(done_seen), 64'd0);

        // Restart after abort, random backpressure
        begin_frame(32'd0);
        finish_frame(5000, 1'b1);

        // Address wrap and start ignored mid-run
        anchor_ready = 1'b1;
        begin_frame(32'hFFFF_FFF0);
        row1_seen = 1'b0;
        start_poked = 1'b0;
        done_seen = 0;
        n = 0;
        while (done_seen == 0 && n < 2000) begin
            if (!row1_seen && row_idx == 16'd1 && col_idx == 16'd0) begin
                row1_seen = 1'b1;
                check("wrap_addr", 64'(anchor_addr), 64'h13);
            end
            if (!start_poked && anchor_cnt == 32'd100) begin
                start_poked = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check("wrap_row1_seen", 64'(row1_seen), 64'd1);
        check("wrap_done", 64'(done_seen), 64'd1);
        check("wrap_cnt",  64'(anchor_cnt), 64'd961);
        sb.delete();

        // Asynchronous reset mid-scan
        begin_frame(32'h100);
        for (int i = 0; i < 50; i++) tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(anchor_valid), 64'd0);
        check("arst_addr",  64'(anchor_addr),  64'd0);
        check("arst_col",   64'(col_idx),      64'd0);
        check("arst_row",   64'(row_idx),      64'd0);
        check("arst_cnt",   64'(anchor_cnt),   64'd0);
        check("arst_busy",  64'(busy),         64'd0);
        check("arst_last",  64'(anchor_last),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        begin_frame(32'h100);
        finish_frame(2000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
